// File: rtl/ddr_serializer_tx.sv
// Double-edge serial transmitter: a handshake loads a word, the first bit pair appears the next cycle, one pair per cycle.
// Backpressure: s_ready is high only when idle or on the last pair of a word, so back-to-back words leave no gap.
module ddr_serializer_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ddr_out,
  output logic             ddr_en,
  output logic             ddr_frame
);

  localparam int NPAIR = WIDTH / 2;
  localparam int CW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int SHW   = (WIDTH > 2) ? WIDTH - 2 : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NPAIR - 1);

  logic             hi_q, lo_q;
  logic [CW-1:0]    cnt;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] ord;
  logic [SHW-1:0]   sh_load, sh_shift;
  logic             sh_hi, sh_lo;
  logic             accept;

  // Reorder so that ord[WIDTH-1] is always the first bit on the wire.
  always_comb begin
    ord = s_data;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) ord[i] = s_data[WIDTH-1-i];
    end
  end

  generate
    if (WIDTH > 2) begin : g_sh
      assign sh_load  = ord[WIDTH-3:0];
      assign sh_hi    = sh[SHW-1];
      assign sh_lo    = sh[SHW-2];
      assign sh_shift = sh << 2;
    end else begin : g_nosh
      assign sh_load  = '0;
      assign sh_hi    = 1'b0;
      assign sh_lo    = 1'b0;
      assign sh_shift = '0;
    end
  endgenerate

  assign s_ready = reset && (!ddr_en || cnt == '0);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q      <= 1'b0;
      lo_q      <= 1'b0;
      sh        <= '0;
      cnt       <= '0;
      ddr_en    <= 1'b0;
      ddr_frame <= 1'b0;
    end else if (accept) begin
      hi_q      <= ord[WIDTH-1];
      lo_q      <= ord[WIDTH-2];
      sh        <= sh_load;
      cnt       <= CNT_LOAD;
      ddr_en    <= 1'b1;
      ddr_frame <= 1'b1;
    end else if (ddr_en && cnt != '0) begin
      hi_q      <= sh_hi;
      lo_q      <= sh_lo;
      sh        <= sh_shift;
      cnt       <= cnt - CW'(1);
      ddr_frame <= 1'b0;
    end else begin
      // Word finished with nothing queued: return the line to idle-low.
      hi_q      <= 1'b0;
      lo_q      <= 1'b0;
      ddr_en    <= 1'b0;
      ddr_frame <= 1'b0;
    end
  end

  // Level-selected output: high phase carries the earlier bit of the pair.
  assign ddr_out = clk ? hi_q : lo_q;

endmodule

// File: tb/tb_ddr_serializer_tx.sv
// Directed bench for ddr_serializer_tx: MSB-first and LSB-first 8-bit instances plus a 2-bit instance.
module tb_ddr_serializer_tx;

  logic       clk;
  logic       reset;
  logic [7:0] s_data0, s_data1;
  logic [1:0] s_data2;
  logic       s_valid0, s_valid1, s_valid2;
  logic       s_ready0, s_ready1, s_ready2;
  logic       out0, out1, out2;
  logic       en0, en1, en2;
  logic       fr0, fr1, fr2;

  logic [2:0] hi_v, lo_v, en_v, fr_v, rdy_v;
  int checks = 0;
  int errors = 0;

  ddr_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset(reset), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
    .ddr_out(out0), .ddr_en(en0), .ddr_frame(fr0));

  ddr_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset(reset), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .ddr_out(out1), .ddr_en(en1), .ddr_frame(fr1));

  ddr_serializer_tx #(.WIDTH(2), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .reset(reset), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .ddr_out(out2), .ddr_en(en2), .ddr_frame(fr2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clk cycle: sample high phase after the posedge, low phase after the negedge.
  task automatic cyc();
    @(posedge clk);
    #2;
    hi_v  = {out2, out1, out0};
    en_v  = {en2, en1, en0};
    fr_v  = {fr2, fr1, fr0};
    rdy_v = {s_ready2, s_ready1, s_ready0};
    @(negedge clk);
    #2;
    lo_v  = {out2, out1, out0};
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input int k, input logic ehi, input logic elo,
                            input logic een, input logic efr, input logic erdy);
    chk({tag, ".hi"},    hi_v[k],  ehi);
    chk({tag, ".lo"},    lo_v[k],  elo);
    chk({tag, ".en"},    en_v[k],  een);
    chk({tag, ".frame"}, fr_v[k],  efr);
    chk({tag, ".ready"}, rdy_v[k], erdy);
  endtask

  logic [7:0] e_hi, e_lo, e_fr, e_rdy;

  initial begin
    reset    = 1'b0;
    s_valid0 = 1'b1; s_data0 = 8'hFF;
    s_valid1 = 1'b0; s_data1 = 8'h00;
    s_valid2 = 1'b0; s_data2 = 2'b00;

    // 1: reset held with a word offered
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_cyc($sformatf("t1_rst_c%0d", i), 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("t1_rdy1_c%0d", i), rdy_v[1], 1'b0);
      chk($sformatf("t1_rdy2_c%0d", i), rdy_v[2], 1'b0);
    end
    reset = 1'b1; s_valid0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      expect_cyc($sformatf("t1_rel_c%0d", i), 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // 2: single word 8'hA5, MSB first
    s_valid0 = 1'b1; s_data0 = 8'hA5;
    e_hi = 8'b0000_0011; e_lo = 8'b0000_1100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      s_valid0 = 1'b0;
      expect_cyc($sformatf("t2_c%0d", i + 1), 0, e_hi[i], e_lo[i], 1'b1, i == 0, i == 3);
    end
    cyc();
    expect_cyc("t2_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3: back-to-back 8'hA5 then 8'h3C
    s_valid0 = 1'b1; s_data0 = 8'hA5;
    e_hi = 8'b0110_0011; e_lo = 8'b0110_1100; e_fr = 8'b0001_0001; e_rdy = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      expect_cyc($sformatf("t3_c%0d", i + 1), 0, e_hi[i], e_lo[i], 1'b1, e_fr[i], e_rdy[i]);
      if (i == 3) s_data0 = 8'h3C;
      if (i == 4) s_valid0 = 1'b0;
    end
    cyc();
    expect_cyc("t3_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4: LSB-first instance, word 8'h01
    s_valid1 = 1'b1; s_data1 = 8'h01;
    for (int i = 0; i < 4; i++) begin
      cyc();
      s_valid1 = 1'b0;
      expect_cyc($sformatf("t4_c%0d", i + 1), 1, i == 0, 1'b0, 1'b1, i == 0, i == 3);
    end
    cyc();
    expect_cyc("t4_idle", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 5: reset during cycle 2 of 8'hA5, then 8'hFF
    s_valid0 = 1'b1; s_data0 = 8'hA5;
    cyc();
    s_valid0 = 1'b0;
    expect_cyc("t5_c1", 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    expect_cyc("t5_c2", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();
    expect_cyc("t5_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; s_valid0 = 1'b1; s_data0 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      cyc();
      s_valid0 = 1'b0;
      expect_cyc($sformatf("t5_ff_c%0d", i + 1), 0, 1'b1, 1'b1, 1'b1, i == 0, i == 3);
    end
    cyc();
    expect_cyc("t5_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6: data churns while busy; only the word present at the handshake edge goes out
    s_valid0 = 1'b1; s_data0 = 8'hA5;
    e_hi = 8'b1010_0011; e_lo = 8'b1010_1100; e_fr = 8'b0001_0001; e_rdy = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      expect_cyc($sformatf("t6_c%0d", i + 1), 0, e_hi[i], e_lo[i], 1'b1, e_fr[i], e_rdy[i]);
      if (i == 0) s_data0 = 8'h11;
      if (i == 1) s_data0 = 8'h22;
      if (i == 2) s_data0 = 8'h33;
      if (i == 4) s_valid0 = 1'b0;
    end
    cyc();
    expect_cyc("t6_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // WIDTH=2: one word per cycle, ready never drops
    s_valid2 = 1'b1; s_data2 = 2'b10;
    cyc();
    s_data2 = 2'b01;
    expect_cyc("w2_c1", 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc();
    s_valid2 = 1'b0;
    expect_cyc("w2_c2", 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc();
    expect_cyc("w2_idle", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
